spi_master_arbiter: RTL and testbench
=====================================

# spi_master_arbiter

Shares one `spi_master` between NREQ requesters. It picks a requester by round-robin, launches the master with that requester's byte, waits for the master's `busy` to rise and fall, and returns the captured MISO byte with a one-cycle `done` pulse. It sits between the client logic and the master's `start`/`mosi_data`/`busy`/`miso_data` pins. No client drives the master directly.

## Interface
- `DWIDTH`, 8: SPI word width; must match the `spi_master` instance.
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 255: watchdog limit in clk cycles. Used only with `SPI_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req` in NREQ: level request, one bit per requester.
- `req_data` in NREQ*DWIDTH: MOSI byte; requester i uses bits [i*DWIDTH +: DWIDTH].
- `grant` out NREQ: one-hot; marks the owner of the current transfer.
- `done` out NREQ: one-cycle pulse to the owner when its transfer completes.
- `rsp_data` out DWIDTH: MISO byte; valid in the `done` cycle and held until the next `done`.
- `timeout` out 1: sticky error flag; exists only with the macro.
- `m_start` out 1: to master `start`.
- `m_mosi_data` out DWIDTH: to master `mosi_data`.
- `m_busy` in 1: from master `busy`.
- `m_miso_data` in DWIDTH: from master `miso_data`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_BUSY, XFER, COMPLETE.
- IDLE, `req`≠0:
  - Choose the winner by round-robin, starting the search at `rr_ptr`.
  - Register `grant` one-hot.
  - Latch the winner's `req_data` into `m_mosi_data`.
  - Go to LAUNCH.
- LAUNCH: `m_start`=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: wait for `m_busy`=1, then XFER.
- XFER: wait for `m_busy`=0, then COMPLETE.
- COMPLETE:
  - Capture `m_miso_data` into `rsp_data`.
  - Pulse `done`[owner].
  - Clear `grant`.
  - Set `rr_ptr` = owner+1 mod NREQ; NREQ-1 wraps to 0.
  - Return to IDLE.
- Requests are sampled only in IDLE. Dropping `req` after grant does not abort the transfer; `done` still pulses.
- A requester holding `req` through its `done` is re-eligible. It loses to any other pending requester because of the rotated pointer.
- With all `req` high, grants rotate 0,1,2,…,NREQ-1,0.
- `m_mosi_data` is stable from LAUNCH through COMPLETE.

## Timing
- Reset values: `grant`=0, `done`=0, `rsp_data`=0, `m_start`=0, `m_mosi_data`=0, `timeout`=0, `rr_ptr`=0, state IDLE.
- Reset mid-transfer: the arbiter returns to IDLE immediately and no `done` is issued. The master shares the same `reset` and is expected to abort too.
- Cycle timing, with `req` seen high at edge N:
  - N: `grant` high.
  - N+1: `m_start` high.
  - N+2 onward: wait for `busy`.
  - Busy-low edge M: `done` at M+1.
- Minimum gap between back-to-back transfers: `done` and the next `grant` are never in the same cycle. The next `grant` comes at `done`+1.
- `done` never pulses to more than one bit. `grant` is never multi-hot.
- `m_busy` already high in IDLE is ignored, and LAUNCH proceeds. WAIT_BUSY then moves on at once. The bench must not do this.

## Configuration
- Macro: `SPI_ARB_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT_BUSY and XFER.
  - When it reaches `TIMEOUT_CYC`, the arbiter:
    - sets `timeout` (sticky until `reset`);
    - pulses `done`[owner] with `rsp_data` = all ones;
    - returns to IDLE, advancing `rr_ptr` as normal.
- Undefined: no counter and no `timeout` port; the FSM waits indefinitely.

## Structure
- Package `spi_arb_pkg`:
  - state enum `spi_arb_state_t`;
  - state encodings;
  - default `DWIDTH` and `NREQ` constants.
- Sub-module `rr_arbiter` (combinational):
  - inputs `req` and `rr_ptr`;
  - outputs a one-hot winner and its index.
- The top level holds the FSM, data latches and the optional watchdog.

## Test plan
- Single request: `req`=0001, `req_data`[0]=C5, slave returns 5A.
  - Expect `grant`=0001, one `m_start` pulse, `m_mosi_data`=C5.
  - Expect `done`=0001 one cycle after `busy` falls, `rsp_data`=5A.
- All four `req` held high for 8 transfers: grant order 0,1,2,3,0,1,2,3; each `done` matches the owner.
- Requester 2 drops `req` in XFER: `done`[2] still pulses and no extra `m_start` is issued.
- `reset` asserted in XFER: all outputs 0 at once; after release, a new `req`=1000 gives `grant`=1000 (`rr_ptr`=0 search order).
- `SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=20, `m_busy` stuck high: `timeout`=1 after 20 cycles in WAIT_BUSY/XFER, `done` pulses, `rsp_data`=FF.
- Back-to-back requests from requesters 0 and 1: the second `grant` comes exactly one cycle after the first `done`.

Source files
------------

// File: rtl/spi_master_arbiter_pkg.sv
// spi_arb_pkg
// Shared definitions for the SPI master arbiter: FSM state encoding,
// default word width / requester count, and an index-width helper.
// No ports (package).
package spi_arb_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int NREQ_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_XFER      = 3'd3,
    ST_COMPLETE  = 3'd4
  } spi_arb_state_t;

  // Bits needed to index n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin picker. The search starts at rr_ptr and walks
// upward with wrap-around; the first requester found wins.
// Ports:
//   req     in  NREQ : request vector
//   rr_ptr  in  IW   : index where the search starts
//   winner  out NREQ : one-hot winner (all zero when req is zero)
//   win_idx out IW   : index of the winner (zero when req is zero)
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   win_idx
);

  // Rotated priority search; sum is one bit wider so ptr + i cannot overflow.
  always_comb begin
    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end else begin
        sum = sum;
      end
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        winner[cand] = 1'b1;
        win_idx      = cand;
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
// Shares one spi_master among NREQ requesters. A round-robin winner is
// granted, its byte is launched on the master, and once the master's busy
// has risen and fallen the captured MISO byte is returned with a one-cycle
// done pulse to the owner.
// Optional feature: define SPI_ARB_TIMEOUT_EN to add a watchdog that ends a
// stuck transfer after TIMEOUT_CYC cycles, returns all ones and sets the
// sticky timeout flag.
// Ports:
//   clk, reset   : clock (rising edge), async active-high reset
//   req          : level requests, one bit per requester
//   req_data     : MOSI bytes, requester i at [i*DWIDTH +: DWIDTH]
//   grant        : one-hot owner of the current transfer
//   done         : one-cycle completion pulse to the owner
//   rsp_data     : MISO byte, valid with done and held until the next done
//   timeout      : sticky watchdog flag (only with SPI_ARB_TIMEOUT_EN)
//   m_start, m_mosi_data, m_busy, m_miso_data : spi_master handshake
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int NREQ        = NREQ_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [DWIDTH-1:0]      rsp_data,
`ifdef SPI_ARB_TIMEOUT_EN
  output logic                   timeout,
`endif
  output logic                   m_start,
  output logic [DWIDTH-1:0]      m_mosi_data,
  input  logic                   m_busy,
  input  logic [DWIDTH-1:0]      m_miso_data
);

  localparam int IW = idx_width(NREQ);

  spi_arb_state_t    state;
  spi_arb_state_t    state_next;
  logic [NREQ-1:0]   win_onehot;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     owner;
  logic [DWIDTH-1:0] win_data;
  logic [DWIDTH-1:0] rsp_next;
  logic              to_hit;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (win_onehot),
    .win_idx (win_idx)
  );

  // Select the winner's MOSI byte with constant slices only.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_data = req_data[i*DWIDTH +: DWIDTH];
      end else begin
        win_data = win_data;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wd_cnt;
  logic          to_flag;

  assign to_hit   = ((state == ST_WAIT_BUSY) || (state == ST_XFER)) &&
                    (wd_cnt == CW'(TIMEOUT_CYC - 1));
  assign rsp_next = to_flag ? {DWIDTH{1'b1}} : m_miso_data;

  // Watchdog: counts cycles spent waiting on the master; to_flag marks that
  // the coming COMPLETE was forced, and timeout latches until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      to_flag <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if ((state == ST_WAIT_BUSY) || (state == ST_XFER)) begin
        wd_cnt <= to_hit ? '0 : wd_cnt + CW'(1);
      end else begin
        wd_cnt <= '0;
      end
      if (to_hit) begin
        to_flag <= 1'b1;
      end else if (state == ST_COMPLETE) begin
        to_flag <= 1'b0;
      end
      if ((state == ST_COMPLETE) && to_flag) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  assign to_hit   = 1'b0;
  assign rsp_next = m_miso_data;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; busy is only examined after the launch cycle, so a
  // busy already high in IDLE does not stall LAUNCH.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (|req) state_next = ST_LAUNCH;
        else      state_next = ST_IDLE;
      end
      ST_LAUNCH:    state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (to_hit)      state_next = ST_COMPLETE;
        else if (m_busy) state_next = ST_XFER;
        else             state_next = ST_WAIT_BUSY;
      end
      ST_XFER: begin
        if (to_hit || !m_busy) state_next = ST_COMPLETE;
        else                   state_next = ST_XFER;
      end
      ST_COMPLETE:  state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Registered outputs: grant/owner/MOSI latch in IDLE, start pulse after
  // LAUNCH, response capture and pointer rotation in COMPLETE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant       <= '0;
      done        <= '0;
      rsp_data    <= '0;
      m_start     <= 1'b0;
      m_mosi_data <= '0;
      rr_ptr      <= '0;
      owner       <= '0;
    end else begin
      m_start <= (state == ST_LAUNCH);
      done    <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant       <= win_onehot;
            owner       <= win_idx;
            m_mosi_data <= win_data;
          end
        end
        ST_COMPLETE: begin
          rsp_data <= rsp_next;
          done     <= grant;
          grant    <= '0;
          rr_ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
        end
        default: begin
          grant <= grant;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [7:0] mosi;
    logic [7:0] rsp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  rsp_data;
  logic        m_start;
  logic [7:0]  m_mosi_data;
  logic        m_busy = 1'b0;
  logic [7:0]  m_miso_data = 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int busy_len = 4;
  int s_cnt = 0;
  logic [7:0] s_mosi = 8'h00;
  vec_t tbl [15];

  always #5 clk = ~clk;

  spi_master_arbiter #(.DWIDTH(8), .NREQ(4), .TIMEOUT_CYC(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .done        (done),
    .rsp_data    (rsp_data),
`ifdef SPI_ARB_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .m_start     (m_start),
    .m_mosi_data (m_mosi_data),
    .m_busy      (m_busy),
    .m_miso_data (m_miso_data)
  );

  // Slave model: on start, busy for busy_len cycles, then returns mosi ^ 9F.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        s_cnt  = 0;
        m_busy = 1'b0;
      end else if (s_cnt != 0) begin
        s_cnt = s_cnt - 1;
        if (s_cnt == 0) begin
          m_miso_data = s_mosi ^ 8'h9F;
          m_busy      = 1'b0;
        end
      end else if (m_start === 1'b1) begin
        s_mosi = m_mosi_data;
        m_busy = 1'b1;
        s_cnt  = busy_len;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_start === 1'b1) start_cnt = start_cnt + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant == 4'b0000 && n < 30) begin
      tick();
      n = n + 1;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done == 4'b0000 && n < 60) begin
      tick();
      n = n + 1;
    end
  endtask

  task automatic wait_busy;
    int n;
    n = 0;
    while (m_busy !== 1'b1 && n < 30) begin
      tick();
      n = n + 1;
    end
    chk("busy_seen", {31'd0, m_busy}, 32'd1);
  endtask

  initial begin
    int n;
    int g_at, s_at, fall_at, d_at;
    logic seen_busy;
    logic [3:0] d_val;

    // requester bytes: r0=C5 r1=A1 r2=3C r3=7E; slave returns byte ^ 9F
    tbl[0]  = '{4'b1111, 4'b0001, 8'hC5, 8'h5A};
    tbl[1]  = '{4'b1111, 4'b0010, 8'hA1, 8'h3E};
    tbl[2]  = '{4'b1111, 4'b0100, 8'h3C, 8'hA3};
    tbl[3]  = '{4'b1111, 4'b1000, 8'h7E, 8'hE1};
    tbl[4]  = '{4'b1111, 4'b0001, 8'hC5, 8'h5A};
    tbl[5]  = '{4'b1111, 4'b0010, 8'hA1, 8'h3E};
    tbl[6]  = '{4'b1111, 4'b0100, 8'h3C, 8'hA3};
    tbl[7]  = '{4'b1111, 4'b1000, 8'h7E, 8'hE1};
    tbl[8]  = '{4'b0001, 4'b0001, 8'hC5, 8'h5A};
    tbl[9]  = '{4'b0101, 4'b0100, 8'h3C, 8'hA3};
    tbl[10] = '{4'b0011, 4'b0001, 8'hC5, 8'h5A};
    tbl[11] = '{4'b1001, 4'b1000, 8'h7E, 8'hE1};
    tbl[12] = '{4'b0010, 4'b0010, 8'hA1, 8'h3E};
    tbl[13] = '{4'b0011, 4'b0001, 8'hC5, 8'h5A};
    tbl[14] = '{4'b0110, 4'b0010, 8'hA1, 8'h3E};

    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h7E3CA1C5;
    repeat (3) tick();
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_rsp", {24'd0, rsp_data}, 32'd0);
    chk("rst_start", {31'd0, m_start}, 32'd0);
    chk("rst_mosi", {24'd0, m_mosi_data}, 32'd0);
`ifdef SPI_ARB_TIMEOUT_EN
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Table: round-robin order, data path, back-to-back spacing.
    req = tbl[0].req;
    for (int k = 0; k < 15; k++) begin
      wait_grant(n);
      if (k > 0) chk("b2b_gap", n, 32'd1);
      chk("grant", {28'd0, grant}, {28'd0, tbl[k].grant});
      chk("mosi", {24'd0, m_mosi_data}, {24'd0, tbl[k].mosi});
      wait_done(n);
      chk("done", {28'd0, done}, {28'd0, tbl[k].grant});
      chk("rsp", {24'd0, rsp_data}, {24'd0, tbl[k].rsp});
      chk("grant_clr", {28'd0, grant}, 32'd0);
      chk("mosi_hold", {24'd0, m_mosi_data}, {24'd0, tbl[k].mosi});
      req = (k < 14) ? tbl[k+1].req : 4'b0000;
    end
    tick();
    chk("start_cnt_tbl", start_cnt, 32'd15);

    // Cycle-accurate single request: grant N, start N+1, done = busy-low + 1.
    g_at = -1; s_at = -1; fall_at = -1; d_at = -1;
    seen_busy = 1'b0; d_val = 4'b0000;
    req = 4'b0001;
    for (int c = 1; c <= 40 && d_at < 0; c++) begin
      tick();
      if (grant != 4'b0000 && g_at < 0) g_at = c;
      if (m_start === 1'b1 && s_at < 0) s_at = c;
      if (m_busy === 1'b1) seen_busy = 1'b1;
      else if (seen_busy && fall_at < 0) fall_at = c;
      if (done != 4'b0000) begin
        d_at  = c;
        d_val = done;
        req   = 4'b0000;
      end
    end
    chk("lat_grant", g_at, 32'd1);
    chk("lat_start", s_at, 32'd2);
    chk("lat_done", d_at - fall_at, 32'd1);
    chk("lat_done_val", {28'd0, d_val}, 32'd1);
    chk("lat_rsp", {24'd0, rsp_data}, 32'h5A);
    tick();
    chk("done_one_cycle", {28'd0, done}, 32'd0);
    chk("start_cnt_lat", start_cnt, 32'd16);

    // Requester 2 drops req during XFER.
    req = 4'b0100;
    wait_grant(n);
    chk("drop_grant", {28'd0, grant}, 32'h4);
    wait_busy();
    req = 4'b0000;
    wait_done(n);
    chk("drop_done", {28'd0, done}, 32'h4);
    chk("drop_rsp", {24'd0, rsp_data}, 32'hA3);
    repeat (5) tick();
    chk("drop_no_grant", {28'd0, grant}, 32'd0);
    chk("drop_start_cnt", start_cnt, 32'd17);

    // Reset during XFER; pointer (3 before reset) must return to 0.
    req = 4'b0010;
    wait_grant(n);
    wait_busy();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", {28'd0, grant}, 32'd0);
    chk("mid_rst_done", {28'd0, done}, 32'd0);
    chk("mid_rst_start", {31'd0, m_start}, 32'd0);
    chk("mid_rst_mosi", {24'd0, m_mosi_data}, 32'd0);
    chk("mid_rst_rsp", {24'd0, rsp_data}, 32'd0);
    req = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    tick();
    req = 4'b1010;
    wait_grant(n);
    chk("post_rst_grant", {28'd0, grant}, 32'h2);
    wait_done(n);
    req = 4'b0000;
    chk("post_rst_done", {28'd0, done}, 32'h2);
    chk("post_rst_rsp", {24'd0, rsp_data}, 32'h3E);
    repeat (2) tick();
    req = 4'b1000;
    wait_grant(n);
    chk("post_rst_grant3", {28'd0, grant}, 32'h8);
    wait_done(n);
    req = 4'b0000;
    chk("post_rst_done3", {28'd0, done}, 32'h8);
    repeat (2) tick();

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: busy stuck high well beyond TIMEOUT_CYC.
    busy_len = 500;
    req = 4'b0001;
    wait_grant(n);
    chk("to_grant", {28'd0, grant}, 32'h1);
    wait_done(n);
    req = 4'b0000;
    chk("to_done", {28'd0, done}, 32'h1);
    chk("to_rsp", {24'd0, rsp_data}, 32'hFF);
    chk("to_flag", {31'd0, timeout}, 32'd1);
    repeat (3) tick();
    chk("to_sticky", {31'd0, timeout}, 32'd1);
    reset = 1'b1;
    tick();
    chk("to_cleared", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    busy_len = 4;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
